// File: rtl/operand_fetch_if.sv
// Upstream/downstream bundle for operand_fetch: decoded instruction in, resolved operand bundle out.
interface operand_fetch_if #(
    parameter int DATA_WIDTH = 32,
    parameter int CTRL_WIDTH = 16
);
    logic                  in_valid;
    logic                  in_ready;
    logic [4:0]            in_rs1_addr;
    logic [4:0]            in_rs2_addr;
    logic [4:0]            in_rd_addr;
    logic [DATA_WIDTH-1:0] in_imm;
    logic [CTRL_WIDTH-1:0] in_ctrl;

    logic                  out_valid;
    logic                  out_ready;
    logic [DATA_WIDTH-1:0] out_rs1_data;
    logic [DATA_WIDTH-1:0] out_rs2_data;
    logic [4:0]            out_rd_addr;
    logic [DATA_WIDTH-1:0] out_imm;
    logic [CTRL_WIDTH-1:0] out_ctrl;

    // Upstream decode + downstream execute side
    modport master (
        output in_valid, in_rs1_addr, in_rs2_addr, in_rd_addr, in_imm, in_ctrl, out_ready,
        input  in_ready, out_valid, out_rs1_data, out_rs2_data, out_rd_addr, out_imm, out_ctrl
    );

    // The operand fetch stage itself
    modport slave (
        input  in_valid, in_rs1_addr, in_rs2_addr, in_rd_addr, in_imm, in_ctrl, out_ready,
        output in_ready, out_valid, out_rs1_data, out_rs2_data, out_rd_addr, out_imm, out_ctrl
    );
endinterface

// File: rtl/operand_fetch.sv
// One-entry operand fetch stage: drives register file reads, merges a same-cycle
// writeback bypass, forces x0 to zero and hands complete bundles to execute.
module operand_fetch #(
    parameter int DATA_WIDTH = 32,
    parameter int CTRL_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  flush,
    operand_fetch_if.slave        bus,
    output logic [4:0]            rf_rs1_addr,
    output logic [4:0]            rf_rs2_addr,
    input  logic [DATA_WIDTH-1:0] rf_rs1_data,
    input  logic [DATA_WIDTH-1:0] rf_rs2_data,
    input  logic                  wb_en,
    input  logic [4:0]            wb_addr,
    input  logic [DATA_WIDTH-1:0] wb_data
);
    logic                  out_valid_reg;
    logic [4:0]            rd_reg;
    logic [DATA_WIDTH-1:0] imm_reg;
    logic [CTRL_WIDTH-1:0] ctrl_reg;
    logic                  in_ready;
    logic                  accept;

    logic [4:0]            in_rs_addr [2];
    logic [4:0]            rf_addr    [2];
    logic [DATA_WIDTH-1:0] rf_data    [2];
    logic [DATA_WIDTH-1:0] out_data   [2];

    assign in_ready = !out_valid_reg || bus.out_ready;
    assign accept   = bus.in_valid && in_ready && !flush;

    assign in_rs_addr[0] = bus.in_rs1_addr;
    assign in_rs_addr[1] = bus.in_rs2_addr;
    assign rf_data[0]    = rf_rs1_data;
    assign rf_data[1]    = rf_rs2_data;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_port
            logic [4:0]            addr_reg;
            logic                  fwd_reg;
            logic [DATA_WIDTH-1:0] fwd_data_reg;

            // While stalled the held address is re-read every cycle, so committed writes show up on their own.
            assign rf_addr[gi] = accept ? in_rs_addr[gi] : addr_reg;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    addr_reg     <= 5'd0;
                    fwd_reg      <= 1'b0;
                    fwd_data_reg <= '0;
                end else begin
                    if (accept) begin
                        addr_reg <= in_rs_addr[gi];
                    end
                    // The file returns the old value on a same-cycle write; capture the new one here.
                    fwd_reg      <= !flush && wb_en && (wb_addr == rf_addr[gi]) && (rf_addr[gi] != 5'd0);
                    fwd_data_reg <= wb_data;
                end
            end

            // x0 has no storage in the file, so its read data is never trusted.
            assign out_data[gi] = !out_valid_reg       ? '0 :
                                  (addr_reg == 5'd0)   ? '0 :
                                  fwd_reg              ? fwd_data_reg :
                                                         rf_data[gi];
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_reg <= 1'b0;
            rd_reg        <= 5'd0;
            imm_reg       <= '0;
            ctrl_reg      <= '0;
        end else begin
            if (flush) begin
                out_valid_reg <= 1'b0;
            end else if (accept) begin
                out_valid_reg <= 1'b1;
            end else if (bus.out_ready) begin
                out_valid_reg <= 1'b0;
            end
            if (accept) begin
                rd_reg   <= bus.in_rd_addr;
                imm_reg  <= bus.in_imm;
                ctrl_reg <= bus.in_ctrl;
            end
        end
    end

    assign rf_rs1_addr      = rf_addr[0];
    assign rf_rs2_addr      = rf_addr[1];
    assign bus.in_ready     = in_ready;
    assign bus.out_valid    = out_valid_reg;
    assign bus.out_rs1_data = out_data[0];
    assign bus.out_rs2_data = out_data[1];
    assign bus.out_rd_addr  = rd_reg;
    assign bus.out_imm      = imm_reg;
    assign bus.out_ctrl     = ctrl_reg;
endmodule

// File: tb/tb_operand_fetch.sv
// Scoreboard bench for operand_fetch with a register file model as environment and an
// architectural register state as the reference for operand values.
module tb_operand_fetch;
    localparam int DW = 32;
    localparam int CW = 16;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          flush = 1'b0;
    logic [4:0]    rf_rs1_addr, rf_rs2_addr;
    logic [DW-1:0] rf_rs1_data = '0;
    logic [DW-1:0] rf_rs2_data = '0;
    logic          wb_en = 1'b0;
    logic [4:0]    wb_addr = '0;
    logic [DW-1:0] wb_data = '0;

    int n_cmp = 0;
    int n_bad = 0;

    operand_fetch_if #(.DATA_WIDTH(DW), .CTRL_WIDTH(CW)) bus ();

    operand_fetch #(.DATA_WIDTH(DW), .CTRL_WIDTH(CW)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .flush       (flush),
        .bus         (bus),
        .rf_rs1_addr (rf_rs1_addr),
        .rf_rs2_addr (rf_rs2_addr),
        .rf_rs1_data (rf_rs1_data),
        .rf_rs2_data (rf_rs2_data),
        .wb_en       (wb_en),
        .wb_addr     (wb_addr),
        .wb_data     (wb_data)
    );

    always #5 clk = ~clk;

    // Register file environment: registered reads, old value on same-cycle write, no x0 storage.
    logic [DW-1:0] rf_mem [32] = '{default: '0};
    always @(posedge clk) begin
        rf_rs1_data <= (rf_rs1_addr == 5'd0) ? 32'hBAD0_BAD0 : rf_mem[rf_rs1_addr];
        rf_rs2_data <= (rf_rs2_addr == 5'd0) ? 32'hBAD0_BAD0 : rf_mem[rf_rs2_addr];
        if (wb_en && wb_addr != 5'd0) rf_mem[wb_addr] <= wb_data;
    end

    // Reference: architectural registers plus queue of accepted instructions.
    typedef struct {
        logic [4:0]    rs1;
        logic [4:0]    rs2;
        logic [4:0]    rd;
        logic [DW-1:0] imm;
        logic [CW-1:0] ctrl;
    } exp_t;
    exp_t          exp_q [$];
    logic [DW-1:0] arch [32] = '{default: '0};

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            exp_q.delete();
        end else begin
            if (flush) exp_q.delete();
            else if (bus.in_valid && bus.in_ready)
                exp_q.push_back('{bus.in_rs1_addr, bus.in_rs2_addr, bus.in_rd_addr, bus.in_imm, bus.in_ctrl});
            if (wb_en && wb_addr != 5'd0) arch[wb_addr] <= wb_data;
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: every cycle compare the presented bundle against the queue head.
    always @(negedge clk) begin
        if (rst_n) begin
            automatic logic exp_v = (exp_q.size() != 0);
            chk("out_valid", {63'd0, bus.out_valid}, {63'd0, exp_v});
            chk("in_ready", {63'd0, bus.in_ready}, {63'd0, !exp_v || bus.out_ready});
            if (exp_v) begin
                automatic exp_t e = exp_q[0];
                automatic logic [DW-1:0] e1 = (e.rs1 == 5'd0) ? '0 : arch[e.rs1];
                automatic logic [DW-1:0] e2 = (e.rs2 == 5'd0) ? '0 : arch[e.rs2];
                n_cmp++;
                if (bus.out_rs1_data !== e1 || bus.out_rs2_data !== e2 || bus.out_rd_addr !== e.rd ||
                    bus.out_imm !== e.imm || bus.out_ctrl !== e.ctrl) begin
                    n_bad++;
                    $display("FAIL bundle: got rs1=%h rs2=%h rd=%0d imm=%h ctrl=%h expected rs1=%h rs2=%h rd=%0d imm=%h ctrl=%h at %0t",
                             bus.out_rs1_data, bus.out_rs2_data, bus.out_rd_addr, bus.out_imm, bus.out_ctrl,
                             e1, e2, e.rd, e.imm, e.ctrl, $time);
                end else begin
                    $display("bundle rd=%0d rs1=%h rs2=%h ready=%0b", e.rd, e1, e2, bus.out_ready);
                end
                if (bus.out_ready) void'(exp_q.pop_front());
            end else begin
                chk("idle_rs1_zero", {32'd0, bus.out_rs1_data}, 64'd0);
                chk("idle_rs2_zero", {32'd0, bus.out_rs2_data}, 64'd0);
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic set_in(input logic v, input logic [4:0] rs1, input logic [4:0] rs2,
                          input logic [4:0] rd, input logic [DW-1:0] imm, input logic [CW-1:0] ctrl);
        bus.in_valid    = v;
        bus.in_rs1_addr = rs1;
        bus.in_rs2_addr = rs2;
        bus.in_rd_addr  = rd;
        bus.in_imm      = imm;
        bus.in_ctrl     = ctrl;
    endtask

    task automatic issue(input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                         input logic [DW-1:0] imm, input logic [CW-1:0] ctrl);
        int k = 0;
        set_in(1'b1, rs1, rs2, rd, imm, ctrl);
        @(negedge clk);
        while (!bus.in_ready && k < 50) begin
            @(negedge clk);
            k++;
        end
        if (k >= 50) chk("issue_timeout", 64'd1, 64'd0);
        cyc();
        bus.in_valid = 1'b0;
    endtask

    task automatic wb(input logic [4:0] a, input logic [DW-1:0] d);
        wb_en = 1'b1; wb_addr = a; wb_data = d;
        cyc();
        wb_en = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        set_in(1'b0, 5'd0, 5'd0, 5'd0, '0, '0);
        bus.out_ready = 1'b0;
        #12;
        chk("rst_in_ready", {63'd0, bus.in_ready}, 64'd1);
        chk("rst_out_valid", {63'd0, bus.out_valid}, 64'd0);
        chk("rst_rf_addr", {54'd0, rf_rs1_addr, rf_rs2_addr}, 64'd0);
        chk("rst_out_data", {bus.out_rs1_data, bus.out_rs2_data}, 64'd0);
        chk("rst_held", {27'd0, bus.out_rd_addr, bus.out_imm}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        cyc();
        bus.out_ready = 1'b1;
        wb(5'd5, 32'h0000_1234);
        wb(5'd7, 32'h0000_0001);
        wb(5'd9, 32'h0000_0011);

        // Plain read plus x0 operand
        issue(5'd5, 5'd0, 5'd3, 32'h1, 16'h1);
        chk("basic_rs1", {32'd0, bus.out_rs1_data}, 64'h1234);
        chk("basic_rs2_x0", {32'd0, bus.out_rs2_data}, 64'd0);

        // Same-cycle writeback bypass
        wb_en = 1'b1; wb_addr = 5'd7; wb_data = 32'hDEAD_BEEF;
        issue(5'd7, 5'd5, 5'd4, 32'h2, 16'h2);
        wb_en = 1'b0;
        chk("bypass_rs1", {32'd0, bus.out_rs1_data}, 64'hDEAD_BEEF);
        cyc();

        // Stall tracking a write to the held source
        bus.out_ready = 1'b0;
        issue(5'd0, 5'd9, 5'd12, 32'h0000_CAFE, 16'h5A5A);
        chk("stall_rs2_old", {32'd0, bus.out_rs2_data}, 64'h11);
        cyc();
        wb_en = 1'b1; wb_addr = 5'd9; wb_data = 32'hA5A5_0001;
        chk("stall_in_ready", {63'd0, bus.in_ready}, 64'd0);
        cyc();
        wb_en = 1'b0;
        chk("stall_rs2_new", {32'd0, bus.out_rs2_data}, 64'hA5A5_0001);
        chk("stall_held", {27'd0, bus.out_rd_addr, bus.out_imm}, {27'd0, 5'd12, 32'h0000_CAFE});
        chk("stall_ctrl", {48'd0, bus.out_ctrl}, 64'h5A5A);
        bus.out_ready = 1'b1;
        cyc();

        // Writes to x0 never reach the operand
        wb_en = 1'b1; wb_addr = 5'd0; wb_data = 32'hFFFF_FFFF;
        issue(5'd0, 5'd5, 5'd1, 32'h3, 16'h3);
        wb_en = 1'b0;
        chk("x0_write_rs1", {32'd0, bus.out_rs1_data}, 64'd0);
        cyc();

        // Back-to-back, one bundle per cycle
        for (int i = 0; i < 4; i++) begin
            set_in(1'b1, 5'(i + 5), 5'(9 - i), 5'(20 + i), 32'(100 + i), 16'(i));
            if (i > 0) chk("b2b_in_ready", {63'd0, bus.in_ready}, 64'd1);
            cyc();
        end
        bus.in_valid = 1'b0;
        chk("b2b_last_rd", {59'd0, bus.out_rd_addr}, 64'd23);
        cyc();

        // Flush with a stalled bundle and a new instruction
        bus.out_ready = 1'b0;
        issue(5'd5, 5'd7, 5'd2, 32'h4, 16'h4);
        cyc();
        flush = 1'b1;
        set_in(1'b1, 5'd9, 5'd9, 5'd6, 32'h5, 16'h5);
        cyc();
        flush = 1'b0;
        bus.in_valid = 1'b0;
        chk("flush_out_valid", {63'd0, bus.out_valid}, 64'd0);
        cyc();
        chk("flush_dropped", {63'd0, bus.out_valid}, 64'd0);

        // Asynchronous reset mid-stall
        issue(5'd5, 5'd9, 5'd8, 32'h6, 16'h6);
        cyc();
        #2 rst_n = 1'b0;
        #1;
        chk("arst_out_valid", {63'd0, bus.out_valid}, 64'd0);
        chk("arst_out_data", {bus.out_rs1_data, bus.out_rs2_data}, 64'd0);
        chk("arst_held", {27'd0, bus.out_rd_addr, bus.out_imm}, 64'd0);
        chk("arst_in_ready", {63'd0, bus.in_ready}, 64'd1);
        @(negedge clk);
        rst_n = 1'b1;
        bus.out_ready = 1'b1;
        cyc();

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            set_in(($urandom % 4) != 0, 5'($urandom % 8), 5'($urandom % 8), 5'($urandom),
                   32'($urandom), 16'($urandom));
            bus.out_ready = ($urandom % 4) != 0;
            flush = ($urandom % 16) == 0;
            wb_en = $urandom % 2;
            wb_addr = 5'($urandom % 8);
            wb_data = 32'($urandom);
            cyc();
        end
        set_in(1'b0, 5'd0, 5'd0, 5'd0, '0, '0);
        flush = 1'b0;
        wb_en = 1'b0;
        bus.out_ready = 1'b1;
        repeat (4) cyc();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/operand_fetch.md
Name: operand_fetch

Overview:
- Issue-side neighbour of the 2-read/1-write register file, which has 1-cycle registered reads and no storage for x0.
- Accepts decoded instructions over a valid/ready handshake and drives the register file read addresses.
- Merges the read data with a writeback bypass and forces x0 to zero.
- Presents complete operand bundles to execute over a second valid/ready handshake; one-entry stage, full throughput.

Parameters:
DATA_WIDTH, 32, operand/writeback data width; must match the register file.
CTRL_WIDTH, 16, opaque decoded control bits passed through unchanged.

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
flush  in  1  synchronous kill of the held instruction
in_valid  in  1  decoded instruction valid
in_ready  out  1  stage can accept
in_rs1_addr  in  5  source 1 index
in_rs2_addr  in  5  source 2 index
in_rd_addr  in  5  destination index
in_imm  in  DATA_WIDTH  immediate
in_ctrl  in  CTRL_WIDTH  control bits
rf_rs1_addr  out  5  register file read address 1
rf_rs2_addr  out  5  register file read address 2
rf_rs1_data  in  DATA_WIDTH  register file read data 1, valid 1 cycle after address
rf_rs2_data  in  DATA_WIDTH  register file read data 2
wb_en  in  1  writeback write enable; same net as the register file wr_en
wb_addr  in  5  writeback index; same net as rd_addr
wb_data  in  DATA_WIDTH  writeback data; same net as rd_data
out_valid  out  1  operand bundle valid
out_ready  in  1  execute accepts
out_rs1_data  out  DATA_WIDTH  resolved operand 1
out_rs2_data  out  DATA_WIDTH  resolved operand 2
out_rd_addr  out  5  held rd
out_imm  out  DATA_WIDTH  held immediate
out_ctrl  out  CTRL_WIDTH  held control

Behaviour:
- Handshake and accept:
  - in_ready = !out_valid || out_ready, combinational. Transfer occurs when in_valid && in_ready; "accept" means transfer && !flush.
  - On accept at edge T: latch rs1/rs2/rd addresses, imm and ctrl into hold registers; out_valid=1 from T+1 (1-cycle latency).
  - If out_valid && out_ready && no accept: out_valid=0 next cycle.
  - Back-to-back accepts give one bundle per cycle.
- Read addresses: rf_rsN_addr = accept ? in_rsN_addr : held rsN address, combinational. The register file therefore re-reads the held address every cycle while stalled, picking up committed writes automatically.
- Same-cycle write bypass (the register file returns the old value on a same-cycle read/write):
  - Each edge: fwdN <= wb_en && (wb_addr == rf_rsN_addr) && (rf_rsN_addr != 0); fwdN_data <= wb_data.
- Operand mux, combinational from registered sources: out_rsN_data = !out_valid ? 0 : (held rsN == 0) ? 0 : fwdN ? fwdN_data : rf_rsN_data.
  - x0 never reads register file data; the file has no x0 entry and its read regs are unreset.
- Stall: out_valid && !out_ready holds all out_* stable except out_rsN_data, which must track writes to the held source. The new value is visible 1 cycle after the wb edge, via fwd then via re-read; there is never a stale window.
- Flush (synchronous):
  - out_valid <= 0, fwd1/fwd2 <= 0; any same-cycle in_valid is dropped (flush has priority).
  - in_ready is not gated by flush.
- Reset (async, rst_n=0): out_valid=0, fwd flags=0, held addresses/rd/imm/ctrl=0. Hence in_ready=1, rf addresses=0 and all out data=0 during and after reset. Mid-transfer reset discards the instruction.
- Outputs out_rd_addr/out_imm/out_ctrl are direct from hold registers, so they read 0 after reset.

Test Plan:
- Reset, then rf x5 = 0x0000_1234; issue rs1=5, rs2=0, out_ready=1 -> out_valid 1 cycle later, out_rs1_data=0x0000_1234, out_rs2_data=0.
- Issue rs1=7 in the same cycle as wb_en=1, wb_addr=7, wb_data=0xDEAD_BEEF (old x7=0x1) -> out_rs1_data=0xDEAD_BEEF, not 0x1.
- Hold out_ready=0 for 3 cycles with rs2=9; write x9=0xA5A5_0001 in stall cycle 2 -> in_ready=0 throughout; out_rs2_data changes to 0xA5A5_0001 the next cycle; rd/imm/ctrl unchanged.
- wb_en=1, wb_addr=0, wb_data=0xFFFF_FFFF while issuing rs1=0 -> out_rs1_data=0.
- 4 back-to-back instructions with out_ready=1 -> 4 bundles on 4 consecutive cycles, in order; in_ready stays 1.
- Assert flush with in_valid=1 while a bundle is stalled -> out_valid=0 next cycle and both instructions are dropped. Deassert rst_n mid-stall -> out_valid=0 and outputs=0 immediately.
